// File: rtl/dither_gen_pkg.sv
// Shared definitions for the dither generator.
// Holds the GPIO command field positions, the register address map,
// the mode and FSM state enums, and a helper that decodes the MODE field.
package dither_gen_pkg;

  // Field positions inside the 32-bit command word.
  localparam int unsigned TOGGLE_BIT = 31;
  localparam int unsigned ADDR_MSB   = 30;
  localparam int unsigned ADDR_LSB   = 28;
  localparam int unsigned DATA_MSB   = 27;
  localparam int unsigned CH_MSB     = 27;
  localparam int unsigned CH_LSB     = 24;
  localparam int unsigned MODE_MSB   = 1;
  localparam int unsigned MODE_LSB   = 0;
  localparam int unsigned RUN_BIT    = 2;
  localparam int unsigned BN_MSB     = 15;
  localparam int unsigned BN_LSB     = 8;

  // Register address map.
  localparam logic [2:0] ADDR_PERIOD = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_VAL0   = 3'd2;
  localparam logic [2:0] ADDR_VAL1   = 3'd3;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_BURST  = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The reserved encoding 3 behaves exactly like HOLD.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_SQUARE;
      2'd2:    return MODE_BURST;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/dither_gen_timer_gp_cmd_decoder.sv
// GPIO command decoder.
// Synchronises the PS GPIO word into the ADC clock domain (2 flops),
// detects level changes of the write-toggle bit and presents a
// one-cycle write strobe with the synchronised address and data.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   gp_i         : raw GPIO command word (asynchronous)
//   wr_o         : one-cycle write strobe
//   addr_o       : register address
//   data_o       : 28-bit data field
module gp_cmd_decoder
  import dither_gen_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [GPIO_WIDTH-1:0] gp_i,
  output logic                  wr_o,
  output logic [2:0]            addr_o,
  output logic [DATA_MSB:0]     data_o
);

  logic [31:0] meta_q;
  logic [31:0] sync_q;
  logic        tog_q;
  logic [2:0]  prime_q;
  logic        unused_gp;

  // Only the architected low 32 bits are synchronised.
  assign unused_gp = ^gp_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= '0;
      sync_q  <= '0;
      tog_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      meta_q  <= gp_i[31:0];
      sync_q  <= meta_q;
      tog_q   <= sync_q[TOGGLE_BIT];
      prime_q <= {prime_q[1:0], 1'b1};
    end
  end

  // Strobes are held off until the toggle-history flop has captured a
  // genuinely synchronised level, so a toggle left high across reset
  // does not replay the last command.
  assign wr_o   = prime_q[2] & (sync_q[TOGGLE_BIT] ^ tog_q);
  assign addr_o = sync_q[ADDR_MSB:ADDR_LSB];
  assign data_o = sync_q[DATA_MSB:0];

endmodule

// File: rtl/dither_gen_timer.sv
// Multi-channel two-level DAC dither generator.
// Register file (shadowed PERIOD/VAL0/VAL1, immediate CTRL), phase FSM
// and counters. Each channel alternates between its two levels every
// P cycles; TICK marks each phase change, DONE marks burst completion.
// Ports:
//   ADC_CLK, RST : clock, synchronous active-high reset
//   GP_IN        : GPIO command word (asynchronous)
//   DAC_OUT      : channel c at [c*DAC_WIDTH +: DAC_WIDTH], registered
//   PHASE, TICK, BUSY, DONE : registered status outputs
module dither_gen_timer
  import dither_gen_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH   = 32,
  parameter int unsigned DAC_WIDTH    = 14,
  parameter int unsigned N_CH         = 2,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                      ADC_CLK,
  input  logic                      RST,
  input  logic [GPIO_WIDTH-1:0]     GP_IN,
  output logic [N_CH*DAC_WIDTH-1:0] DAC_OUT,
  output logic                      PHASE,
  output logic                      TICK,
  output logic                      BUSY,
  output logic                      DONE
);

  logic              wr;
  logic [2:0]        waddr;
  logic [DATA_MSB:0] wdata;
  logic [3:0]        wch;

  logic [PERIOD_WIDTH-1:0] per_sh_q, per_sh_d, per_act_q, per_act_d, pm1;
  logic [DAC_WIDTH-1:0]    v0_sh_q [N_CH], v0_sh_d [N_CH], v0_act_q [N_CH], v0_act_d [N_CH];
  logic [DAC_WIDTH-1:0]    v1_sh_q [N_CH], v1_sh_d [N_CH], v1_act_q [N_CH], v1_act_d [N_CH];
  mode_e                   mode_q, mode_d;
  logic                    run_q, run_d, ctrl_wr, run_ok;
  logic [7:0]              bn_q, bn_d;

  state_e                   state_q;
  logic [PERIOD_WIDTH-1:0]  cnt_q;
  logic [8:0]               ph_q, ph_target;
  logic                     phase_q, tick_q, done_q, busy_q, boundary, burst_end;
  logic [N_CH*DAC_WIDTH-1:0] dac_q, dac_v0, dac_v1;

  gp_cmd_decoder #(.GPIO_WIDTH(GPIO_WIDTH)) u_dec (
    .clk_i (ADC_CLK),
    .rst_i (RST),
    .gp_i  (GP_IN),
    .wr_o  (wr),
    .addr_o(waddr),
    .data_o(wdata)
  );

  assign wch = wdata[CH_MSB:CH_LSB];

  // Register-file write decode.
  always_comb begin
    per_sh_d = per_sh_q;
    v0_sh_d  = v0_sh_q;
    v1_sh_d  = v1_sh_q;
    mode_d   = mode_q;
    run_d    = run_q;
    bn_d     = bn_q;
    ctrl_wr  = 1'b0;
    if (wr) begin
      case (waddr)
        ADDR_PERIOD: per_sh_d = wdata[PERIOD_WIDTH-1:0];
        ADDR_CTRL: begin
          ctrl_wr = 1'b1;
          mode_d  = decode_mode(wdata[MODE_MSB:MODE_LSB]);
          run_d   = wdata[RUN_BIT];
          bn_d    = wdata[BN_MSB:BN_LSB];
        end
        ADDR_VAL0: for (int unsigned c = 0; c < N_CH; c++)
                     if (wch == 4'(c)) v0_sh_d[c] = wdata[DAC_WIDTH-1:0];
        ADDR_VAL1: for (int unsigned c = 0; c < N_CH; c++)
                     if (wch == 4'(c)) v1_sh_d[c] = wdata[DAC_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign run_ok    = run_d && (mode_d == MODE_SQUARE || mode_d == MODE_BURST);
  assign pm1       = (per_act_q == '0) ? '0 : per_act_q - 1'b1;
  assign boundary  = (state_q == S_RUN) && (cnt_q == pm1);
  assign ph_target = {((bn_q == 8'd0) ? 8'd1 : bn_q), 1'b0};
  assign burst_end = (mode_q == MODE_BURST) && ((ph_q + 9'd1) == ph_target);

  // Active registers: follow the shadows while not running; while running
  // they take the pre-write shadow at a boundary, so a write landing on the
  // boundary cycle applies one boundary later.
  always_comb begin
    if (state_q != S_RUN) begin
      per_act_d = per_sh_d;
      v0_act_d  = v0_sh_d;
      v1_act_d  = v1_sh_d;
    end else if (boundary) begin
      per_act_d = per_sh_q;
      v0_act_d  = v0_sh_q;
      v1_act_d  = v1_sh_q;
    end else begin
      per_act_d = per_act_q;
      v0_act_d  = v0_act_q;
      v1_act_d  = v1_act_q;
    end
  end

  always_comb begin
    dac_v0 = '0;
    dac_v1 = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      dac_v0[c*DAC_WIDTH +: DAC_WIDTH] = v0_act_d[c];
      dac_v1[c*DAC_WIDTH +: DAC_WIDTH] = v1_act_d[c];
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      per_sh_q  <= '0;
      per_act_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        v0_sh_q[c]  <= '0;
        v0_act_q[c] <= '0;
        v1_sh_q[c]  <= '0;
        v1_act_q[c] <= '0;
      end
      mode_q  <= MODE_HOLD;
      run_q   <= 1'b0;
      bn_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dac_q   <= '0;
    end else begin
      per_sh_q  <= per_sh_d;
      per_act_q <= per_act_d;
      v0_sh_q   <= v0_sh_d;
      v0_act_q  <= v0_act_d;
      v1_sh_q   <= v1_sh_d;
      v1_act_q  <= v1_act_d;
      mode_q    <= mode_d;
      run_q     <= run_d;
      bn_q      <= bn_d;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (!run_ok || ctrl_wr) begin
            // Abort, or restart on a CTRL rewrite with RUN still set.
            state_q <= run_ok ? S_RUN : S_IDLE;
            busy_q  <= run_ok;
            cnt_q   <= '0;
            ph_q    <= '0;
            phase_q <= 1'b0;
            dac_q   <= dac_v0;
          end else if (boundary) begin
            cnt_q <= '0;
            if (burst_end) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              run_q   <= 1'b0;
              ph_q    <= '0;
              phase_q <= 1'b0;
              dac_q   <= dac_v0;
            end else begin
              tick_q  <= 1'b1;
              ph_q    <= ph_q + 9'd1;
              phase_q <= ~phase_q;
              dac_q   <= phase_q ? dac_v0 : dac_v1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          phase_q <= 1'b0;
          dac_q   <= dac_v0;
        end
        default: begin
          cnt_q   <= '0;
          ph_q    <= '0;
          phase_q <= 1'b0;
          dac_q   <= dac_v0;
          busy_q  <= run_ok;
          state_q <= run_ok ? S_RUN : S_IDLE;
        end
      endcase
    end
  end

  assign DAC_OUT = dac_q;
  assign PHASE   = phase_q;
  assign TICK    = tick_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_dither_gen_timer.sv
module tb_dither_gen_timer;

  localparam int unsigned GW = 32;
  localparam int unsigned DW = 14;
  localparam int unsigned NC = 2;
  localparam int unsigned PW = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [GW-1:0]    gp;
  logic [NC*DW-1:0] dac;
  logic             phase, tick, busy, done;

  int   checks = 0;
  int   errors = 0;
  int   ticks;
  logic tog = 1'b0;

  dither_gen_timer #(
    .GPIO_WIDTH  (GW),
    .DAC_WIDTH   (DW),
    .N_CH        (NC),
    .PERIOD_WIDTH(PW)
  ) dut (
    .ADC_CLK(clk),
    .RST    (rst),
    .GP_IN  (gp),
    .DAC_OUT(dac),
    .PHASE  (phase),
    .TICK   (tick),
    .BUSY   (busy),
    .DONE   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NC*DW-1:0] e_dac,
                         input logic e_ph, input logic e_tick, input logic e_busy,
                         input logic e_done);
    chk({tag, ".dac"},   64'(dac),   64'(e_dac));
    chk({tag, ".phase"}, 64'(phase), 64'(e_ph));
    chk({tag, ".tick"},  64'(tick),  64'(e_tick));
    chk({tag, ".busy"},  64'(busy),  64'(e_busy));
    chk({tag, ".done"},  64'(done),  64'(e_done));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which the write commits.
  task automatic wr(input logic [2:0] a, input logic [27:0] d);
    @(negedge clk);
    tog = ~tog;
    gp  = {tog, a, d};
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    gp  = '0;
    step(3);
    chk_all("reset", '0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(5);

    // Square wave, P=4, ch0 levels 0x0100 / 0x3F00.
    wr(3'd0, 28'd4);
    chk("period_idle.dac", 64'(dac), 64'h0);
    wr(3'd2, 28'h0000100);
    chk("val0_idle.dac", 64'(dac), 64'h100);
    wr(3'd3, 28'h0003F00);
    chk("val1_idle.dac", 64'(dac), 64'h100);
    wr(3'd1, 28'h0000005);
    chk_all("sq_start", 28'h100, 0, 0, 1, 0);
    step(3);
    chk_all("sq_e3", 28'h100, 0, 0, 1, 0);
    step(1);
    chk_all("sq_e4", 28'h3F00, 1, 1, 1, 0);
    step(1);
    chk_all("sq_e5", 28'h3F00, 1, 0, 1, 0);
    step(3);
    chk_all("sq_e8", 28'h100, 0, 1, 1, 0);
    step(4);
    chk_all("sq_e12", 28'h3F00, 1, 1, 1, 0);

    // Abort mid-phase (commits at E15, one cycle before the E16 boundary).
    wr(3'd1, 28'h0000001);
    chk_all("abort", 28'h100, 0, 0, 0, 0);
    step(1);
    chk_all("abort_next", 28'h100, 0, 0, 0, 0);

    // Burst, P=2, BURST_N=3: 5 ticks then DONE 12 cycles after BUSY rise.
    wr(3'd0, 28'd2);
    wr(3'd1, 28'h0000306);
    chk("burst_start.busy", 64'(busy), 64'h1);
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (tick) ticks++;
      if (i == 11) chk("burst_e11.done", 64'(done), 64'h0);
    end
    chk("burst.ticks", 64'(ticks), 64'd5);
    chk_all("burst_done", 28'h100, 0, 0, 0, 1);
    step(1);
    chk_all("burst_after", 28'h100, 0, 0, 0, 0);

    // Shadowed VAL1 ch1 update while running with P=8.
    wr(3'd3, 28'h1000AAA);
    wr(3'd0, 28'd8);
    wr(3'd1, 28'h0000005);
    step(8);
    chk_all("sh_e8", 28'h2AABF00, 1, 1, 1, 0);
    wr(3'd3, 28'h1001234);
    chk("sh_e11.dac", 64'(dac), 64'h2AABF00);
    step(4);
    chk("sh_e15.dac", 64'(dac), 64'h2AABF00);
    step(1);
    chk_all("sh_e16", 28'h100, 0, 1, 1, 0);
    step(7);
    chk("sh_e23.dac", 64'(dac), 64'h100);
    step(1);
    chk_all("sh_e24", 28'h48D3F00, 1, 1, 1, 0);

    // PERIOD=0 behaves as P=1.
    wr(3'd1, 28'h0000000);
    chk("p0_abort.busy", 64'(busy), 64'h0);
    wr(3'd0, 28'd0);
    wr(3'd1, 28'h0000005);
    chk_all("p0_start", 28'h100, 0, 0, 1, 0);
    step(1);
    chk_all("p0_e1", 28'h48D3F00, 1, 1, 1, 0);
    step(1);
    chk_all("p0_e2", 28'h100, 0, 1, 1, 0);
    step(1);
    chk_all("p0_e3", 28'h48D3F00, 1, 1, 1, 0);

    // Ignored address and out-of-range channel.
    wr(3'd1, 28'h0000000);
    wr(3'd5, 28'hFFFFFFF);
    chk_all("addr5", 28'h100, 0, 0, 0, 0);
    wr(3'd2, 28'hF003333);
    chk_all("ch15", 28'h100, 0, 0, 0, 0);

    // Reset mid-run, then stale toggle level must not replay a write.
    wr(3'd0, 28'd4);
    wr(3'd1, 28'h0000005);
    step(5);
    chk_all("pre_rst", 28'h48D3F00, 1, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    chk_all("rst_mid", '0, 0, 0, 0, 0);
    step(1);
    @(negedge clk);
    rst = 1'b0;
    step(8);
    chk_all("post_rst", '0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
